// File: rtl/tap_pkg.sv
// Shared constants for the TAP scan datapath: default opcodes, IR capture
// pattern, default IDCODE and the data-register select type.
package tap_pkg;

  localparam logic [3:0]  OP_IDCODE  = 4'h1;
  localparam logic [3:0]  OP_USER    = 4'h2;
  localparam logic [3:0]  OP_BYPASS  = 4'hF;
  localparam logic [1:0]  IR_CAPTURE = 2'b01;
  localparam logic [31:0] IDCODE_VAL = 32'h1234_5ABF;

  typedef enum logic [1:0] {
    SEL_BYPASS,
    SEL_IDCODE,
    SEL_USER
  } dr_sel_e;

endpackage

// File: rtl/tap_shift_reg.sv
// Generic scan shift register: parallel capture, serial right shift with
// tdi entering the MSB; bit 0 is the serial output.
module tap_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             tclk,
  input  logic             trst,
  input  logic             capture,
  input  logic             shift,
  input  logic             tdi,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] shift_next;

  // Built per bit so a one-bit register needs no special slicing.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      if (gi == WIDTH - 1) begin : g_msb
        assign shift_next[gi] = tdi;
      end else begin : g_mid
        assign shift_next[gi] = data_reg[gi+1];
      end
    end
  endgenerate

  always_ff @(posedge tclk) begin
    if (trst) begin
      data_reg <= '0;
    end else if (capture) begin
      data_reg <= pdata;
    end else if (shift) begin
      data_reg <= shift_next;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/tap_ir_dr_chain.sv
// Instruction register plus BYPASS / IDCODE / USER data registers driven by
// the TAP controller's state strobes; produces tdo and the latched USER value.
module tap_ir_dr_chain
  import tap_pkg::*;
#(
  parameter int                   IR_WIDTH   = 4,
  parameter int                   DR_WIDTH   = 8,
  parameter logic [31:0]          IDCODE_VAL = tap_pkg::IDCODE_VAL,
  parameter logic [IR_WIDTH-1:0]  OP_IDCODE  = IR_WIDTH'(tap_pkg::OP_IDCODE),
  parameter logic [IR_WIDTH-1:0]  OP_USER    = IR_WIDTH'(tap_pkg::OP_USER),
  parameter logic [IR_WIDTH-1:0]  OP_BYPASS  = IR_WIDTH'(tap_pkg::OP_BYPASS)
) (
  input  logic                tclk,
  input  logic                trst,
  input  logic                tdi,
  input  logic                test_logic_reset,
  input  logic                capture_dr,
  input  logic                shift_dr,
  input  logic                update_dr,
  input  logic                capture_ir,
  input  logic                shift_ir,
  input  logic                update_ir,
  input  logic [DR_WIDTH-1:0] udr_in,
  output logic                tdo,
  output logic                tdo_en,
  output logic [IR_WIDTH-1:0] ir_out,
  output logic [DR_WIDTH-1:0] udr_out,
  output logic                udr_update
);

  logic tlr_en, uir_en, udr_en, cir_en, cdr_en, sir_en, sdr_en;
  logic [IR_WIDTH-1:0] ir_out_reg;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [IR_WIDTH-1:0] ir_capture_val;
  logic [31:0]         idcode_shift;
  logic [DR_WIDTH-1:0] user_shift;
  logic [DR_WIDTH-1:0] udr_out_reg;
  logic                udr_update_reg;
  logic                bypass_reg;
  logic                idcode_unused;
  dr_sel_e             dr_sel;

  // Strobes are one-hot by contract; this chain resolves any overlap.
  always_comb begin
    tlr_en = test_logic_reset;
    uir_en = update_ir  & ~tlr_en;
    udr_en = update_dr  & ~tlr_en & ~update_ir;
    cir_en = capture_ir & ~tlr_en & ~update_ir & ~update_dr;
    cdr_en = capture_dr & ~tlr_en & ~update_ir & ~update_dr & ~capture_ir;
    sir_en = shift_ir   & ~tlr_en & ~update_ir & ~update_dr & ~capture_ir & ~capture_dr;
    sdr_en = shift_dr   & ~tlr_en & ~update_ir & ~update_dr & ~capture_ir & ~capture_dr
                        & ~shift_ir;
  end

  always_comb begin
    case (ir_out_reg)
      OP_IDCODE: dr_sel = SEL_IDCODE;
      OP_USER:   dr_sel = SEL_USER;
      OP_BYPASS: dr_sel = SEL_BYPASS;
      default:   dr_sel = SEL_BYPASS;
    endcase
  end

  assign ir_capture_val = IR_WIDTH'(IR_CAPTURE);

  tap_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_shift (
    .tclk    (tclk),
    .trst    (trst),
    .capture (cir_en),
    .shift   (sir_en),
    .tdi     (tdi),
    .pdata   (ir_capture_val),
    .data    (ir_shift)
  );

  tap_shift_reg #(.WIDTH(32)) u_idcode_shift (
    .tclk    (tclk),
    .trst    (trst),
    .capture (cdr_en && dr_sel == SEL_IDCODE),
    .shift   (sdr_en && dr_sel == SEL_IDCODE),
    .tdi     (tdi),
    .pdata   (IDCODE_VAL),
    .data    (idcode_shift)
  );

  tap_shift_reg #(.WIDTH(DR_WIDTH)) u_user_shift (
    .tclk    (tclk),
    .trst    (trst),
    .capture (cdr_en && dr_sel == SEL_USER),
    .shift   (sdr_en && dr_sel == SEL_USER),
    .tdi     (tdi),
    .pdata   (udr_in),
    .data    (user_shift)
  );

  // Only the LSB of IDCODE is ever observed; the rest just shifts through.
  assign idcode_unused = ^idcode_shift[31:1];

  always_ff @(posedge tclk) begin
    if (trst) begin
      ir_out_reg     <= OP_IDCODE;
      bypass_reg     <= 1'b0;
      udr_out_reg    <= '0;
      udr_update_reg <= 1'b0;
    end else begin
      udr_update_reg <= udr_en && dr_sel == SEL_USER;
      if (tlr_en) begin
        ir_out_reg <= OP_IDCODE;
      end else if (uir_en) begin
        ir_out_reg <= ir_shift;
      end
      if (udr_en && dr_sel == SEL_USER) begin
        udr_out_reg <= user_shift;
      end
      if (cdr_en && dr_sel == SEL_BYPASS) begin
        bypass_reg <= 1'b0;
      end else if (sdr_en && dr_sel == SEL_BYPASS) begin
        bypass_reg <= tdi;
      end
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_shift[0];
    end else if (shift_dr) begin
      case (dr_sel)
        SEL_IDCODE: tdo = idcode_shift[0];
        SEL_USER:   tdo = user_shift[0];
        default:    tdo = bypass_reg;
      endcase
    end
  end

  assign tdo_en     = shift_dr | shift_ir;
  assign ir_out     = ir_out_reg;
  assign udr_out    = udr_out_reg;
  assign udr_update = udr_update_reg;

endmodule

// File: doc/tap_ir_dr_chain.md
Name: tap_ir_dr_chain

Overview:
Scan-register datapath directly downstream of the TAP state controller. It consumes the controller's one-hot state strobes (test_logic_reset, capture/shift/update for IR and DR) and implements the instruction register plus three data registers: BYPASS, IDCODE and a USER data register. It drives TDO and exposes the decoded user register to on-chip logic.

Parameters:
IR_WIDTH, 4, instruction register width in bits (minimum 2).
DR_WIDTH, 8, USER data register width in bits.
IDCODE_VAL, 32'h1234_5ABF, 32-bit value captured for IDCODE; bit 0 must be 1.
OP_IDCODE, 4'h1, IR opcode selecting IDCODE.
OP_USER, 4'h2, IR opcode selecting the USER register.
OP_BYPASS, 4'hF, IR opcode selecting BYPASS.

Ports:
tclk  in  1  test clock; all state changes on posedge.
trst  in  1  synchronous, active-high reset.
tdi  in  1  serial data in.
test_logic_reset  in  1  controller state strobe.
capture_dr  in  1  controller state strobe.
shift_dr  in  1  controller state strobe.
update_dr  in  1  controller state strobe.
capture_ir  in  1  controller state strobe.
shift_ir  in  1  controller state strobe.
update_ir  in  1  controller state strobe.
udr_in  in  DR_WIDTH  parallel value captured into the USER shift register.
tdo  out  1  serial data out.
tdo_en  out  1  high while shift_dr or shift_ir is asserted.
ir_out  out  IR_WIDTH  active (latched) instruction.
udr_out  out  DR_WIDTH  latched USER register.
udr_update  out  1  one-cycle pulse when udr_out is loaded.

Behaviour:
- Reset (trst=1 at posedge): ir_out=OP_IDCODE; ir_shift=0; bypass=0; idcode_shift=0; user_shift=0; udr_out=0; udr_update=0. Reset overrides all other inputs, including mid-shift.
- test_logic_reset=1 (trst=0): ir_out=OP_IDCODE; udr_out is held; the shift registers are held.
- Instruction decode: ir_out==OP_IDCODE selects IDCODE; ir_out==OP_USER selects USER; every other code, including OP_BYPASS and unassigned codes, selects BYPASS.
- capture_ir: ir_shift <= {zeros, 2'b01} (LSB=1, bit1=0).
- shift_ir: ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]}. tdo = ir_shift[0], combinational from current register contents.
- update_ir: ir_out <= ir_shift.
- capture_dr: only the selected DR loads. IDCODE loads IDCODE_VAL. USER loads udr_in. BYPASS loads 0.
- shift_dr: only the selected DR shifts right, with tdi entering the MSB; the bypass register is bit <= tdi. tdo = LSB of the selected DR.
- update_dr: if USER is selected, udr_out <= user_shift and udr_update=1 for exactly that cycle; otherwise no effect.
- udr_update is registered: it is high in the cycle after the posedge where update_dr was sampled, and is 0 in all other cycles.
- When neither shift strobe is asserted: tdo=0 and tdo_en=0.
- Strobes are one-hot by contract. If more than one is asserted, priority is test_logic_reset > update_ir > update_dr > capture_ir > capture_dr > shift_ir > shift_dr.
- Latency: 1 bit shifts per tclk. A selected DR of N bits shows its first captured bit at tdo in the shift cycle immediately after capture, so BYPASS delays tdi by exactly 1 cycle.
- An IR change takes effect for DR selection from the cycle after update_ir.

Decomposition:
- Shared package tap_pkg: opcode constants OP_IDCODE, OP_USER, OP_BYPASS; the IR capture pattern 2'b01; the default IDCODE_VAL.
- One sub-module: tap_shift_reg, parameterised by width. It provides capture (parallel load), shift (serial right, tdi to MSB), and a serial-out LSB. It is instantiated for IR, IDCODE and USER; BYPASS is a single flop.

Test Plan:
1. Reset, then capture_dr followed by 32 shift_dr cycles -> tdo serialises 32'h1234_5ABF LSB first (first bit 1); tdo_en=1 throughout.
2. capture_ir, then 4 shift_ir cycles with tdi=1,1,1,1, then update_ir -> tdo reads 1,0,0,0; ir_out=4'hF.
3. IR=BYPASS, capture_dr, shift tdi pattern 1,0,1,1 -> tdo = 0,1,0,1 (one-cycle delay).
4. IR=OP_USER, udr_in=8'h3C, capture_dr, shift 8 cycles with tdi bits of 8'hA5 LSB first, then update_dr -> tdo emits 8'h3C LSB first; udr_out=8'hA5; udr_update pulses for exactly one cycle.
5. IR=4'h7 (unassigned), capture and shift -> behaves as BYPASS; udr_out is unchanged after update_dr and udr_update stays 0.
6. trst asserted for one cycle mid-way through a USER shift -> all registers at reset values, ir_out=OP_IDCODE, tdo=0; a subsequent IDCODE readback is correct.
